// File: rtl/phy_rx_buffer.sv
// Show-ahead receive buffer for PHY words: circular storage, registered head
// word, occupancy flags and sticky overflow/underflow indicators.
module phy_rx_buffer #(
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6
) (
  input  logic                       clk_32f,
  input  logic                       reset,
  input  logic [31:0]                data_in,
  input  logic                       valid_in,
  input  logic                       pop,
  input  logic                       clear_err,
  output logic [31:0]                data_out,
  output logic                       valid_out,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_LVL   = (AW+1)'(AF_THRESH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW-1:0] wr_ptr_next, rd_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic [31:0]   data_reg, data_next;
  logic          overflow_reg, underflow_reg;
  logic          pop_acc, push_acc;

  always_comb begin
    pop_acc     = pop && (count_reg != '0);
    push_acc    = valid_in && ((count_reg != FULL_LVL) || pop_acc);
    wr_ptr_next = push_acc ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
    rd_ptr_next = pop_acc  ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    count_next  = count_reg;
    if (push_acc && !pop_acc)
      count_next = count_reg + (AW+1)'(1);
    else if (pop_acc && !push_acc)
      count_next = count_reg - (AW+1)'(1);
    // The new head is the word being written this cycle only when it lands in
    // the slot the read pointer is about to point at; bypass the array then.
    data_next = 32'h0;
    if (count_next != '0) begin
      if (push_acc && (rd_ptr_next == wr_ptr_reg))
        data_next = data_in;
      else
        data_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk_32f) begin
    if (push_acc)
      mem[wr_ptr_reg] <= data_in;
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      data_reg      <= 32'h0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      data_reg   <= data_next;
      if (clear_err) begin
        overflow_reg  <= 1'b0;
        underflow_reg <= 1'b0;
      end else begin
        if (valid_in && !push_acc)
          overflow_reg <= 1'b1;
        if (pop && (count_reg == '0))
          underflow_reg <= 1'b1;
      end
    end
  end

  assign data_out    = data_reg;
  assign fill_level  = count_reg;
  assign valid_out   = (count_reg != '0);
  assign empty       = (count_reg == '0);
  assign full        = (count_reg == FULL_LVL);
  assign almost_full = (count_reg >= AF_LVL);
  assign overflow    = overflow_reg;
  assign underflow   = underflow_reg;

endmodule

// File: tb/tb_phy_rx_buffer.sv
// Directed bench for phy_rx_buffer: stimulus queues expected words, a monitor
// compares every popped head word; flag checks are made inline.
module tb_phy_rx_buffer;

  logic        clk_32f = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        valid_in;
  logic        pop;
  logic        clear_err;
  logic [31:0] data_out;
  logic        valid_out;
  logic [3:0]  fill_level;
  logic        empty, full, almost_full, overflow, underflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  phy_rx_buffer #(.DEPTH(8), .AF_THRESH(6)) dut (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .pop(pop), .clear_err(clear_err), .data_out(data_out), .valid_out(valid_out),
    .fill_level(fill_level), .empty(empty), .full(full), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive after the edge, hold until the next rising edge.
  task automatic cycle(input logic v, input logic [31:0] d, input logic p, input logic c);
    valid_in = v; data_in = d; pop = p; clear_err = c;
    @(posedge clk_32f); #1;
    valid_in = 0; data_in = 0; pop = 0; clear_err = 0;
  endtask

  task automatic push(input logic [31:0] d);
    exp_q.push_back(d);
    cycle(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_data"}, data_out, 32'h0);
    check({tag, "_valid"}, {31'h0, valid_out}, 32'h0);
    check({tag, "_fill"}, {28'h0, fill_level}, 32'h0);
    check({tag, "_flags"}, {27'h0, empty, full, almost_full, overflow, underflow}, 32'h10);
  endtask

  // Monitor: a pop presented while a head word is valid is a transaction.
  always @(negedge clk_32f) begin
    if (!reset && pop && valid_out) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("[TB] FAIL pop_unexpected: got %h expected none", data_out);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("pop_data", data_out, e);
        $display("[TB] pop data=%h expected=%h", data_out, e);
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; data_in = 0; valid_in = 0; pop = 0; clear_err = 0;
    repeat (2) @(posedge clk_32f);
    #1;
    check_reset_state("reset");
    reset = 0;

    // First word, one-cycle latency
    push(32'hA5A5_0001);
    check("first_data", data_out, 32'hA5A5_0001);
    check("first_valid", {31'h0, valid_out}, 32'h1);
    check("first_fill", {28'h0, fill_level}, 32'h1);
    check("first_empty", {31'h0, empty}, 32'h0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("drain_empty", {31'h0, empty}, 32'h1);

    // Fill to DEPTH, pointers wrap since read pointer starts at 1
    for (int i = 0; i < 8; i++) begin
      push(i);
      if (i == 4) check("af_at5", {31'h0, almost_full}, 32'h0);
      if (i == 5) check("af_at6", {31'h0, almost_full}, 32'h1);
      if (i == 6) check("full_at7", {31'h0, full}, 32'h0);
    end
    check("full_at8", {31'h0, full}, 32'h1);
    check("fill_8", {28'h0, fill_level}, 32'h8);

    // Overflow: dropped word, sticky flag, clear
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("ovf_set", {31'h0, overflow}, 32'h1);
    check("ovf_fill", {28'h0, fill_level}, 32'h8);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check("ovf_clear", {31'h0, overflow}, 32'h0);

    // Full with push and pop together
    exp_q.push_back(32'h1234_5678);
    cycle(1'b1, 32'h1234_5678, 1'b1, 1'b0);
    check("pp_fill", {28'h0, fill_level}, 32'h8);
    check("pp_ovf", {31'h0, overflow}, 32'h0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("drain_empty2", {31'h0, empty}, 32'h1);
    check("drain_data0", data_out, 32'h0);
    check("drain_valid0", {31'h0, valid_out}, 32'h0);

    // Underflow with simultaneous push
    exp_q.push_back(32'h0000_00FF);
    cycle(1'b1, 32'h0000_00FF, 1'b1, 1'b0);
    check("udf_set", {31'h0, underflow}, 32'h1);
    check("udf_fill", {28'h0, fill_level}, 32'h1);
    check("udf_data", data_out, 32'h0000_00FF);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("udf_sticky", {31'h0, underflow}, 32'h1);
    // clear wins over a same-cycle underflow
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("udf_clear_prio", {31'h0, underflow}, 32'h0);

    // 20 push/pop pairs across wrap-around
    push(32'hC000_0000);
    for (int i = 1; i <= 20; i++) begin
      exp_q.push_back(32'hC000_0000 + i);
      cycle(1'b1, 32'hC000_0000 + i, 1'b1, 1'b0);
    end
    check("pairs_fill", {28'h0, fill_level}, 32'h1);
    push(32'hC000_0015);
    push(32'hC000_0016);
    check("pre_rst_fill", {28'h0, fill_level}, 32'h3);

    // Asynchronous reset mid-cycle with activity on the inputs
    valid_in = 1; data_in = 32'hBAD0_0000; pop = 1;
    #2;
    reset = 1;
    #1;
    check_reset_state("async_rst");
    exp_q.delete();
    @(posedge clk_32f); #1;
    check_reset_state("hold_rst");
    valid_in = 0; data_in = 0; pop = 0;
    reset = 0;
    @(posedge clk_32f); #1;
    check_reset_state("post_rst");
    push(32'h0000_0055);
    check("post_rst_data", data_out, 32'h0000_0055);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    check("queue_drained", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
